elevator_design: RTL and testbench

Single-car elevator controller for an 8-floor building (scalable via parameters). Latches floor call requests into a pending-request vector, serves them in SCAN order (keep direction while calls remain ahead), operates the door with dwell, IR-obstruction and overweight holds, and freezes on an emergency input. Sits between the call-button decoder and the motor/door drivers; all outputs are Moore-decoded from registered state.

---
 rtl/elevator_design.sv | 105 ++++++++++
 tb/tb_elevator_design.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/elevator_design.sv
// elevator_design: SCAN-order single-car elevator controller; define ELEVATOR_IR_HOLD_EN to let IR_sensor hold the door open
module elevator_design #(
    parameter int N_FLOORS    = 8,
    parameter int FLOOR_W     = 3,
    parameter int DOOR_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [FLOOR_W-1:0]  req_floor,
    input  logic                emergency,
    input  logic                over_weight,
    input  logic                IR_sensor,
    output logic                up,
    output logic                down,
    output logic                idle,
    output logic                door,
    output logic [FLOOR_W-1:0]  max_request,
    output logic [FLOOR_W-1:0]  min_request,
    output logic                emergency_stop,
    output logic [FLOOR_W-1:0]  current_floor,
    output logic [N_FLOORS-1:0] requests
);
    typedef enum logic [2:0] {S_IDLE, S_UP, S_DOWN, S_DOOR, S_EMERG} state_t;
    localparam int CNT_W = $clog2(DOOR_CYCLES + 1);
    state_t state, ns;
    logic dir;
    logic [CNT_W-1:0] cnt;
    logic [FLOOR_W-1:0] req_prev;
    logic first, capture, in_range, here, above, below, ir_hold;
`ifdef ELEVATOR_IR_HOLD_EN
    assign ir_hold = IR_sensor;
`else
    logic ir_unused;
    assign ir_unused = IR_sensor;
    assign ir_hold = 1'b0;
`endif
    assign capture  = first || req_floor != req_prev;
    assign in_range = 32'(req_floor) < N_FLOORS;
    assign here     = requests[current_floor];
    // Locate pending calls relative to the car and the extreme pending floors
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        min_request = current_floor;
        max_request = current_floor;
        for (int i = N_FLOORS - 1; i >= 0; i--)
            if (requests[i]) min_request = FLOOR_W'(i);
        for (int i = 0; i < N_FLOORS; i++) begin
            if (requests[i]) max_request = FLOOR_W'(i);
            if (requests[i] && FLOOR_W'(i) > current_floor) above = 1'b1;
            if (requests[i] && FLOOR_W'(i) < current_floor) below = 1'b1;
        end
    end
    // Next-state selection; emergency overrides every other decision
    always_comb begin
        ns = state;
        case (state)
            S_IDLE:  ns = here ? S_DOOR : over_weight ? S_IDLE :
                          (above && below) ? (dir ? S_UP : S_DOWN) :
                          above ? S_UP : below ? S_DOWN : S_IDLE;
            S_UP:    ns = here ? S_DOOR : above ? S_UP : S_IDLE;
            S_DOWN:  ns = here ? S_DOOR : below ? S_DOWN : S_IDLE;
            S_DOOR:  ns = (cnt == 0 && !over_weight && !ir_hold) ? S_IDLE : S_DOOR;
            S_EMERG: ns = emergency ? S_EMERG : S_IDLE;
            default: ns = S_IDLE;
        endcase
        if (emergency) ns = S_EMERG;
    end
    // State, position, call latch, dwell counter and registered one-hot outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            current_floor  <= '0;
            requests       <= '0;
            dir            <= 1'b1;
            cnt            <= '0;
            req_prev       <= '0;
            first          <= 1'b1;
            idle           <= 1'b1;
            up             <= 1'b0;
            down           <= 1'b0;
            door           <= 1'b0;
            emergency_stop <= 1'b0;
        end else begin
            first    <= 1'b0;
            req_prev <= req_floor;
            if (capture && in_range) requests[req_floor] <= 1'b1;
            if (ns == S_DOOR && state != S_DOOR) requests[current_floor] <= 1'b0;
            if (ns == S_UP) dir <= 1'b1;
            if (ns == S_DOWN) dir <= 1'b0;
            if (state == S_UP && ns == S_UP && current_floor != FLOOR_W'(N_FLOORS - 1))
                current_floor <= current_floor + 1'b1;
            if (state == S_DOWN && ns == S_DOWN && current_floor != '0)
                current_floor <= current_floor - 1'b1;
            cnt <= (ns == S_DOOR && (state != S_DOOR || ir_hold)) ? CNT_W'(DOOR_CYCLES) :
                   (cnt != 0) ? cnt - 1'b1 : cnt;
            state          <= ns;
            idle           <= ns == S_IDLE;
            up             <= ns == S_UP;
            down           <= ns == S_DOWN;
            door           <= ns == S_DOOR;
            emergency_stop <= ns == S_EMERG;
        end
    end
endmodule

// File: tb/tb_elevator_design.sv
// tb_elevator_design: directed scenarios with a stop-order scoreboard for elevator_design
module tb_elevator_design;
    localparam int NF = 8, FW = 3, DC = 2;
`ifdef ELEVATOR_IR_HOLD_EN
    localparam int IR_EXP = 3 + DC + 1;
`else
    localparam int IR_EXP = DC + 1;
`endif
    logic clock = 1'b0, reset = 1'b0;
    logic [FW-1:0] req_floor = '0;
    logic emergency = 1'b0, over_weight = 1'b0, IR_sensor = 1'b0;
    logic up, down, idle, door, emergency_stop;
    logic [FW-1:0] max_request, min_request, current_floor;
    logic [NF-1:0] requests;
    int checks = 0, errors = 0;
    int exp_q[$];
    logic door_q = 1'b0;

    elevator_design #(.N_FLOORS(NF), .FLOOR_W(FW), .DOOR_CYCLES(DC)) dut (
        .clock(clock), .reset(reset), .req_floor(req_floor), .emergency(emergency),
        .over_weight(over_weight), .IR_sensor(IR_sensor), .up(up), .down(down),
        .idle(idle), .door(door), .max_request(max_request), .min_request(min_request),
        .emergency_stop(emergency_stop), .current_floor(current_floor), .requests(requests)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each door opening is a stop; pop the expected floor and compare
    always @(negedge clock) begin
        if (door && !door_q) begin
            if (exp_q.size() == 0) chk("stop_unexpected", int'(current_floor), 255);
            else chk("stop_floor", int'(current_floor), exp_q.pop_front());
            chk("stop_cleared", int'(requests[current_floor]), 0);
        end
        door_q <= door;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (!(idle && requests == 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("idle_reached", int'(idle && requests == 0), 1);
    endtask

    task automatic wait_door();
        int n = 0;
        while (!door && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("door_reached", int'(door), 1);
    endtask

    initial begin
        int n;
        logic ok;
        // reset values
        repeat (2) @(negedge clock);
        chk("rst_idle", int'(idle), 1);
        chk("rst_motion_door_estop", int'({up, down, door, emergency_stop}), 0);
        chk("rst_floor", int'(current_floor), 0);
        chk("rst_requests", int'(requests), 0);
        chk("rst_min", int'(min_request), 0);
        chk("rst_max", int'(max_request), 0);
        // the first post-reset cycle always captures req_floor (0 here)
        exp_q.push_back(0);
        reset = 1'b1;
        wait_idle();
        // single call
        req_floor = 3'd1;
        exp_q.push_back(1);
        @(negedge clock);
        chk("single_req", int'(requests), 'h02);
        @(negedge clock);
        chk("single_up", int'(up), 1);
        wait_idle();
        chk("single_floor", int'(current_floor), 1);
        // SCAN: calls 4, 3, 7 while heading up from floor 1
        exp_q.push_back(3);
        exp_q.push_back(4);
        exp_q.push_back(7);
        req_floor = 3'd4;
        @(negedge clock);
        req_floor = 3'd3;
        @(negedge clock);
        req_floor = 3'd7;
        @(negedge clock);
        chk("scan_req", int'(requests), 'h98);
        chk("scan_min", int'(min_request), 3);
        chk("scan_max", int'(max_request), 7);
        chk("scan_up", int'(up), 1);
        wait_idle();
        chk("scan_floor", int'(current_floor), 7);
        // travel down to floor 0
        req_floor = 3'd0;
        exp_q.push_back(0);
        wait_idle();
        chk("down_floor", int'(current_floor), 0);
        // emergency mid-travel upward, with a new call captured while frozen
        req_floor = 3'd5;
        exp_q.push_back(5);
        repeat (3) @(negedge clock);
        chk("emg_pre_floor", int'(current_floor), 1);
        chk("emg_pre_up", int'(up), 1);
        emergency = 1'b1;
        @(negedge clock);
        chk("emg_estop", int'(emergency_stop), 1);
        chk("emg_up_off", int'(up), 0);
        chk("emg_floor", int'(current_floor), 1);
        req_floor = 3'd6;
        exp_q.push_back(6);
        @(negedge clock);
        chk("emg_frozen_floor", int'(current_floor), 1);
        chk("emg_capture", int'(requests), 'h60);
        chk("emg_door_closed", int'(door), 0);
        emergency = 1'b0;
        @(negedge clock);
        chk("emg_exit_idle", int'(idle), 1);
        chk("emg_exit_estop", int'(emergency_stop), 0);
        wait_idle();
        chk("emg_resume_floor", int'(current_floor), 6);
        // overweight holds the door
        req_floor = 3'd4;
        exp_q.push_back(4);
        @(negedge clock);
        wait_door();
        over_weight = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (!door) ok = 1'b0;
        end
        chk("ow_door_held", int'(ok), 1);
        over_weight = 1'b0;
        n = 0;
        while (door && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("ow_close_bounded", int'(n >= 1 && n <= DC + 1), 1);
        wait_idle();
        // overweight blocks departure from idle
        over_weight = 1'b1;
        req_floor = 3'd2;
        exp_q.push_back(2);
        repeat (4) @(negedge clock);
        chk("ow_idle_held", int'(idle), 1);
        chk("ow_idle_floor", int'(current_floor), 4);
        chk("ow_idle_req", int'(requests), 'h04);
        over_weight = 1'b0;
        wait_idle();
        chk("ow_release_floor", int'(current_floor), 2);
        // IR obstruction for 3 clocks while the door is open
        req_floor = 3'd3;
        exp_q.push_back(3);
        @(negedge clock);
        wait_door();
        n = 0;
        for (int k = 0; k < 40 && door; k++) begin
            IR_sensor = (k < 3);
            n++;
            @(negedge clock);
        end
        IR_sensor = 1'b0;
        chk("ir_door_cycles", n, IR_EXP);
        wait_idle();
        chk("all_stops_seen", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
